// File: rtl/countdown_timer_n_if.sv
// Control and status bundle for countdown_timer_n: load/start/pause requests in,
// count and status flags out.
interface countdown_timer_n_if #(
    parameter int WIDTH = 4
);
    logic             Load;
    logic [WIDTH-1:0] Load_Value;
    logic             Start;
    logic             Pause;
    logic             Auto_Reload;
    logic [WIDTH-1:0] Count;
    logic             Busy;
    logic             Done;
    logic             Expired;

    modport master (
        output Load, Load_Value, Start, Pause, Auto_Reload,
        input  Count, Busy, Done, Expired
    );

    modport slave (
        input  Load, Load_Value, Start, Pause, Auto_Reload,
        output Count, Busy, Done, Expired
    );
endinterface

// File: rtl/countdown_timer_n.sv
// Loadable prescaled down-counter with stop-on-expiry or auto-reload.
//   state   | meaning
//   IDLE    | loaded or reset, waiting for Start
//   RUN     | prescaler advancing, Count decrements on each tick
//   PAUSE   | frozen, prescaler and Count held
//   EXPIRED | reached zero without auto-reload, Count held at 0
module countdown_timer_n #(
    parameter int          WIDTH = 4,
    parameter int unsigned DIV   = 100000000,
    localparam int         PS_W  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    countdown_timer_n_if.slave   bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_reg;
    logic [PS_W-1:0]  prescaler;
    logic             done;
    logic             tick;

    assign tick = (state == S_RUN) && (prescaler == PS_LAST) && !bus.Pause;

    always_ff @(posedge Clk) begin
        done <= 1'b0;
        if (Reset) begin
            state      <= S_IDLE;
            count      <= '0;
            reload_reg <= '0;
            prescaler  <= '0;
        end else if (bus.Load) begin
            state      <= S_IDLE;
            count      <= bus.Load_Value;
            reload_reg <= bus.Load_Value;
            prescaler  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start && (count != '0)) begin
                        state     <= S_RUN;
                        prescaler <= '0;
                    end
                end
                S_RUN: begin
                    // Pause wins over a pending tick; the prescaler holds at its value
                    if (bus.Pause) begin
                        state <= S_PAUSE;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (count == CNT_ONE) begin
                            done <= 1'b1;
                            if (bus.Auto_Reload) begin
                                count <= reload_reg;
                            end else begin
                                count <= '0;
                                state <= S_EXPIRED;
                            end
                        end else if (count != '0) begin
                            count <= count - CNT_ONE;
                        end
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.Start && !bus.Pause) begin
                        state <= S_RUN;
                    end
                end
                S_EXPIRED: begin
                    if (bus.Start && (reload_reg != '0)) begin
                        count     <= reload_reg;
                        prescaler <= '0;
                        state     <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Count   = count;
    assign bus.Done    = done;
    assign bus.Busy    = (state == S_RUN) || (state == S_PAUSE);
    assign bus.Expired = (state == S_EXPIRED);
endmodule

// File: tb/tb_countdown_timer_n.sv
// Scoreboard bench for countdown_timer_n: directed scenarios followed by random
// stimulus, each cycle's expected outputs predicted from run-cycle arithmetic.
module tb_countdown_timer_n;
    localparam int WIDTH = 4;
    localparam int DIV   = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    countdown_timer_n_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer_n #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int count;
        bit busy;
        bit done;
        bit expired;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;

    // Reference: in RUN, Count = base - (unpaused run cycles since segment start) / DIV
    mode_t m_mode   = M_IDLE;
    int    m_count  = 0;
    int    m_reload = 0;
    int    m_base   = 0;
    int    m_runs   = 0;
    bit    m_done   = 0;
    bit    ar_lvl   = 0;

    task automatic model_step(input bit rst, input bit ld, input int lv,
                              input bit st, input bit pa, input bit ar);
        m_done = 0;
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_reload = 0;
        end else if (ld) begin
            m_mode = M_IDLE; m_count = lv; m_reload = lv;
        end else begin
            case (m_mode)
                M_IDLE: if (st && m_count != 0) begin
                    m_mode = M_RUN; m_base = m_count; m_runs = 0;
                end
                M_RUN: if (pa) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_runs++;
                    if (m_runs % DIV == 0) begin
                        if (m_base - m_runs / DIV == 0) begin
                            m_done = 1;
                            if (ar) begin
                                m_base = m_reload; m_runs = 0; m_count = m_reload;
                            end else begin
                                m_mode = M_EXP; m_count = 0;
                            end
                        end else begin
                            m_count = m_base - m_runs / DIV;
                        end
                    end
                end
                M_PAUSE: if (st && !pa) m_mode = M_RUN;
                M_EXP: if (st && m_reload != 0) begin
                    m_mode = M_RUN; m_base = m_reload; m_runs = 0; m_count = m_reload;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic drive(input bit rst, input bit ld, input int lv,
                         input bit st, input bit pa);
        exp_t e;
        @(negedge Clk);
        Reset           = rst;
        bus.Load        = ld;
        bus.Load_Value  = WIDTH'(lv);
        bus.Start       = st;
        bus.Pause       = pa;
        bus.Auto_Reload = ar_lvl;
        model_step(rst, ld, lv, st, pa, ar_lvl);
        e.count   = m_count;
        e.busy    = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        e.done    = m_done;
        e.expired = (m_mode == M_EXP);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("count",   int'(bus.Count),   e.count);
                check("busy",    int'(bus.Busy),    int'(e.busy));
                check("done",    int'(bus.Done),    int'(e.done));
                check("expired", int'(bus.Expired), int'(e.expired));
            end
        end
    end

    initial begin : stimulus
        Reset = 1'b1;
        bus.Load = 0; bus.Load_Value = '0; bus.Start = 0;
        bus.Pause = 0; bus.Auto_Reload = 0;

        // stop-on-expiry, then hold at zero
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 5, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(41);

        // auto-reload loop
        ar_lvl = 1;
        drive(0, 1, 3, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(40);
        ar_lvl = 0;

        // pause while the prescaler sits at its last value, then resume
        drive(0, 1, 9, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(3);
        repeat (10) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        idle(3);

        // Load beats Start and Pause in the same cycle
        drive(0, 1, 6, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(3);
        drive(0, 1, 2, 1, 1);
        idle(2);

        // Start with zero count, restart from EXPIRED
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 2, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(10);
        drive(0, 0, 0, 1, 1);
        idle(10);

        // reset mid-run, then Start is ignored
        drive(0, 1, 8, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(5);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ar_lvl = ~ar_lvl;
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 39) == 0,
                  int'($urandom_range(0, (1 << WIDTH) - 1)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0);
        end

        @(posedge Clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer_n.md
Name: countdown_timer_n

Overview:
- Loadable down-counter timer. It is the counting-down counterpart of the board's free-running LED up-counter.
- A prescaler divides the 100 MHz board clock into a tick. Each tick decrements Count from a loaded value toward zero.
- On expiry it either signals and stops, or reloads and continues.
- Count drives the board LEDs directly. Done/Expired feed status LEDs or downstream control logic.

Parameters:
- WIDTH, 4: width of Count, Load_Value and the reload register.
- DIV, 100000000: clock cycles per tick. Legal range is 1..2^32-1. Benches use a small value (4).
- PS_W, $clog2(DIV) with a minimum of 1: prescaler width. Derived; not overridden.

Ports:
- Clk  in  1  system clock, single domain.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  load request; held high = load every cycle.
- Load_Value  in  WIDTH  value captured on Load.
- Start  in  1  start / resume / restart request, sampled per cycle.
- Pause  in  1  pause request, sampled per cycle.
- Auto_Reload  in  1  level; selects reload-on-expiry vs stop-on-expiry.
- Count  out  WIDTH  current count (registered).
- Busy  out  1  high in RUN or PAUSE.
- Done  out  1  one-cycle pulse on every terminal tick (registered).
- Expired  out  1  high while in EXPIRED.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high, sampled on posedge Clk only. No asynchronous terms anywhere, including the prescaler (no derived clocks; the tick is an enable).
- Reset response: Count=0, reload_reg=0, prescaler=0, state=IDLE, Done=0, Busy=0, Expired=0. Reset overrides every other input. Reset mid-RUN aborts with no Done pulse.
- States: IDLE, RUN, PAUSE, EXPIRED (binary encoded). Busy and Expired are decoded from registered state.
- Priority within a cycle: Reset > Load > Pause > Start > tick.
- Load (any state):
  - Count <= Load_Value; reload_reg <= Load_Value.
  - prescaler <= 0; state <= IDLE.
  - Done is not pulsed.
- IDLE:
  - Start with Count!=0 -> RUN, prescaler <= 0.
  - Start with Count==0 is ignored (stay IDLE).
  - Pause is ignored.
- Prescaler and tick:
  - Advances only in RUN.
  - tick = (state==RUN) && (prescaler==DIV-1) && !Pause.
  - On tick, prescaler <= 0; otherwise prescaler <= prescaler+1 while in RUN.
  - In PAUSE, and in RUN while Pause is high, the prescaler holds its value.
  - DIV=1 means a tick every RUN cycle.
- RUN:
  - Pause -> PAUSE. No decrement that cycle, even if the prescaler is at DIV-1.
  - Non-terminal tick (Count>1): Count <= Count-1.
  - Terminal tick (Count==1): Done <= 1 for exactly one cycle, then:
    - Auto_Reload=1: Count <= reload_reg, stay in RUN, prescaler <= 0.
    - Auto_Reload=0: Count <= 0, state <= EXPIRED.
- PAUSE:
  - Start without Pause -> RUN. The prescaler resumes from its held value, so a hold at DIV-1 gives a tick on the first RUN cycle.
  - Start and Pause together: stay in PAUSE.
- EXPIRED:
  - Count stays 0.
  - Start with reload_reg!=0: Count <= reload_reg, prescaler <= 0, -> RUN.
  - Start with reload_reg==0: ignored.
  - Pause: ignored.
- Latency: Start at cycle t (IDLE, Count=N>0, no Pause in between):
  - Busy=1 from t+1.
  - Ticks at cycles t+k*DIV for k>=1.
  - Count=N-k visible from t+k*DIV+1.
  - Done high during cycle t+N*DIV+1 only, coincident with Count=0 (or Count=reload_reg if Auto_Reload).
- Arithmetic: unsigned, modulo 2^WIDTH. Count never decrements from 0; there is no underflow path.
- Auto_Reload is sampled only at the terminal tick. Changing it mid-run has no other effect.

Test Plan (WIDTH=4, DIV=4):
1. Reset, Load 5, Start at t -> Busy=1 at t+1; Count 4,3,2,1,0 from t+5, t+9, t+13, t+17, t+21. Done=1 only in cycle t+21. Expired=1 and Busy=0 from t+21. Count held at 0 for 20 further cycles.
2. Load 3, Auto_Reload=1, Start -> sequence 3,2,1,3,2,1,3. Done pulses each time Count goes 1->3, 12 cycles apart. State never reaches EXPIRED.
3. Load 9, Start, Pause for 10 cycles starting when the prescaler is at DIV-1 -> no decrement during the pause; Count stays 9. Start -> Count=8 on the cycle after the first RUN cycle.
4. In RUN with Count=6: assert Load(Load_Value=2), Start and Pause in the same cycle -> next cycle Count=2, state IDLE, Busy=0, Done=0.
5. Start with Count=0 from IDLE -> no change. From EXPIRED after Load 2 and a completed run -> Start reloads Count=2 and enters RUN.
6. Assert Reset mid-RUN with Count=7 -> next cycle Count=0, Busy=0, Done=0, Expired=0. Start is then ignored because Count=0.
